// File: rtl/banco_param_if.sv
// banco_param_if: bundles the decode-side request signals and the registered
// read results of the banco_param register file.
//   Read1Add/Read2Add  read addresses for ports 1 and 2
//   WriteAdd/entrada   write address and write data
//   RW                 write enable
//   leitura            read request for both ports
//   limpa              start a clear sweep
//   dado1/dado2        registered read data
//   valido             read data updated by a read accepted on the last edge
//   ocupado            clear sweep in progress
// The master modport is the decode stage; the slave modport is the register file.
interface banco_param_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);
  logic [ADDR_W-1:0] Read1Add;
  logic [ADDR_W-1:0] Read2Add;
  logic [ADDR_W-1:0] WriteAdd;
  logic [DATA_W-1:0] entrada;
  logic              RW;
  logic              leitura;
  logic              limpa;
  logic [DATA_W-1:0] dado1;
  logic [DATA_W-1:0] dado2;
  logic              valido;
  logic              ocupado;

  modport master (
    output Read1Add, Read2Add, WriteAdd, entrada, RW, leitura, limpa,
    input  dado1, dado2, valido, ocupado
  );

  modport slave (
    input  Read1Add, Read2Add, WriteAdd, entrada, RW, leitura, limpa,
    output dado1, dado2, valido, ocupado
  );
endinterface

// File: rtl/banco_param.sv
// banco_param: parametrised register file with two registered read ports.
//   clock    rising-edge clock
//   reset_n  asynchronous active-low reset; clears registers, outputs and FSM
//   bus      banco_param_if.slave carrying addresses, write data, RW, leitura,
//            limpa and the registered outputs dado1, dado2, valido, ocupado
// Reads have one cycle of latency with write-first bypass. With ZERO_R0=1,
// register 0 is hard-wired to zero. A limpa request starts a sweep that clears
// one register per cycle for DEPTH cycles while ocupado is high.
module banco_param #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 3,
  parameter bit ZERO_R0 = 1'b0
) (
  input logic          clock,
  input logic          reset_n,
  banco_param_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_INDEX = ADDR_W'(DEPTH - 1);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] index_q, index_d;
  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DATA_W-1:0] dado1_q, dado1_d;
  logic [DATA_W-1:0] dado2_q, dado2_d;
  logic              valido_q, valido_d;
  logic              wr_en;

  // A write to register 0 is discarded when it is hard-wired to zero; this also
  // suppresses the bypass, so a read of address 0 returns the stored zero.
  assign wr_en = bus.RW && !(ZERO_R0 && (bus.WriteAdd == '0));

  // Next-state logic. Reads sample regs_q, so a read of a different address in
  // the same cycle as a write returns the old contents.
  always_comb begin
    state_d  = state_q;
    index_d  = index_q;
    regs_d   = regs_q;
    dado1_d  = dado1_q;
    dado2_d  = dado2_q;
    valido_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (wr_en) begin
          regs_d[bus.WriteAdd] = bus.entrada;
        end
        if (bus.leitura) begin
          valido_d = 1'b1;
          dado1_d  = (wr_en && (bus.Read1Add == bus.WriteAdd)) ? bus.entrada
                                                               : regs_q[bus.Read1Add];
          dado2_d  = (wr_en && (bus.Read2Add == bus.WriteAdd)) ? bus.entrada
                                                               : regs_q[bus.Read2Add];
        end
        if (bus.limpa) begin
          state_d = SWEEP;
          index_d = '0;
        end
      end
      SWEEP: begin
        regs_d[index_q] = '0;
        index_d         = index_q + ADDR_W'(1);
        if (index_q == LAST_INDEX) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      index_q  <= '0;
      dado1_q  <= '0;
      dado2_q  <= '0;
      valido_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      index_q  <= index_d;
      dado1_q  <= dado1_d;
      dado2_q  <= dado2_d;
      valido_q <= valido_d;
      regs_q   <= regs_d;
    end
  end

  assign bus.dado1   = dado1_q;
  assign bus.dado2   = dado2_q;
  assign bus.valido  = valido_q;
  assign bus.ocupado = (state_q == SWEEP);
endmodule

// File: tb/tb_banco_param.sv
// tb_banco_param: directed test of banco_param. Instance dut uses the default
// parameters; instance dut_z has ZERO_R0=1 for the hard-wired zero register.
module tb_banco_param;
  logic clock;
  logic reset_n;
  int   vectors;
  int   miscompares;

  banco_param_if #(.DATA_W(16), .ADDR_W(3)) b  ();
  banco_param_if #(.DATA_W(16), .ADDR_W(3)) bz ();

  banco_param #(.DATA_W(16), .ADDR_W(3), .ZERO_R0(1'b0)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (b)
  );

  banco_param #(.DATA_W(16), .ADDR_W(3), .ZERO_R0(1'b1)) dut_z (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bz)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance past the next rising edge; outputs are sampled and inputs changed here.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    b.RW = 1'b0;  b.leitura = 1'b0;  b.limpa = 1'b0;
    b.Read1Add = '0;  b.Read2Add = '0;  b.WriteAdd = '0;  b.entrada = '0;
    bz.RW = 1'b0; bz.leitura = 1'b0; bz.limpa = 1'b0;
    bz.Read1Add = '0; bz.Read2Add = '0; bz.WriteAdd = '0; bz.entrada = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 1'b0;
    #3;
    vectors++;
    if (b.dado1 !== 16'h0000) begin
      miscompares++; $display("FAIL reset_dado1: got %h expected 0000", b.dado1);
    end
    vectors++;
    if (b.dado2 !== 16'h0000) begin
      miscompares++; $display("FAIL reset_dado2: got %h expected 0000", b.dado2);
    end
    vectors++;
    if (b.valido !== 1'b0) begin
      miscompares++; $display("FAIL reset_valido: got %b expected 0", b.valido);
    end
    vectors++;
    if (b.ocupado !== 1'b0) begin
      miscompares++; $display("FAIL reset_ocupado: got %b expected 0", b.ocupado);
    end
    @(negedge clock);
    reset_n = 1'b1;
    // First read after reset returns zeros with valido set.
    b.leitura = 1'b1; b.Read1Add = 3'd5; b.Read2Add = 3'd7;
    tick();
    vectors++;
    if (b.dado1 !== 16'h0000 || b.dado2 !== 16'h0000 || b.valido !== 1'b1) begin
      miscompares++;
      $display("FAIL first_read: got %h/%h/%b expected 0000/0000/1", b.dado1, b.dado2, b.valido);
    end
    b.leitura = 1'b0;
    tick();
    vectors++;
    if (b.valido !== 1'b0) begin
      miscompares++; $display("FAIL valido_drop: got %b expected 0", b.valido);
    end
  endtask

  task automatic test_write_read();
    b.RW = 1'b1; b.WriteAdd = 3'd3; b.entrada = 16'hBEEF;
    tick();
    b.RW = 1'b0; b.leitura = 1'b1; b.Read1Add = 3'd3; b.Read2Add = 3'd4;
    tick();
    b.leitura = 1'b0;
    vectors++;
    if (b.dado1 !== 16'hBEEF || b.valido !== 1'b1) begin
      miscompares++;
      $display("FAIL write_read: got %h/%b expected beef/1", b.dado1, b.valido);
    end
    vectors++;
    if (b.dado2 !== 16'h0000) begin
      miscompares++; $display("FAIL write_read_p2: got %h expected 0000", b.dado2);
    end
    // With leitura low the read data must hold.
    tick();
    vectors++;
    if (b.dado1 !== 16'hBEEF || b.valido !== 1'b0) begin
      miscompares++;
      $display("FAIL read_hold: got %h/%b expected beef/0", b.dado1, b.valido);
    end
  endtask

  task automatic test_bypass();
    b.RW = 1'b1; b.WriteAdd = 3'd2; b.entrada = 16'h1234;
    b.leitura = 1'b1; b.Read1Add = 3'd2; b.Read2Add = 3'd2;
    tick();
    vectors++;
    if (b.dado1 !== 16'h1234 || b.dado2 !== 16'h1234) begin
      miscompares++;
      $display("FAIL bypass_both: got %h/%h expected 1234/1234", b.dado1, b.dado2);
    end
    // Port 1 reads a different address (old contents), port 2 is bypassed.
    b.WriteAdd = 3'd3; b.entrada = 16'h1111; b.Read1Add = 3'd3; b.Read2Add = 3'd3;
    b.Read1Add = 3'd2;
    tick();
    vectors++;
    if (b.dado1 !== 16'h1234 || b.dado2 !== 16'h1111) begin
      miscompares++;
      $display("FAIL bypass_mixed: got %h/%h expected 1234/1111", b.dado1, b.dado2);
    end
    // Port 1 reads address 3 while writing address 6: old value 1111, not the new data.
    b.WriteAdd = 3'd6; b.entrada = 16'h6666; b.Read1Add = 3'd3; b.Read2Add = 3'd6;
    tick();
    vectors++;
    if (b.dado1 !== 16'h1111 || b.dado2 !== 16'h6666) begin
      miscompares++;
      $display("FAIL read_old: got %h/%h expected 1111/6666", b.dado1, b.dado2);
    end
    idle_inputs();
  endtask

  task automatic test_zero_r0();
    bz.RW = 1'b1; bz.WriteAdd = 3'd0; bz.entrada = 16'hFFFF;
    b.RW  = 1'b1; b.WriteAdd  = 3'd0; b.entrada  = 16'h00A5;
    tick();
    bz.RW = 1'b0; bz.leitura = 1'b1; bz.Read1Add = 3'd0; bz.Read2Add = 3'd0;
    b.RW  = 1'b0; b.leitura  = 1'b1; b.Read1Add  = 3'd0;
    tick();
    vectors++;
    if (bz.dado1 !== 16'h0000 || bz.valido !== 1'b1) begin
      miscompares++;
      $display("FAIL zero_r0_read: got %h/%b expected 0000/1", bz.dado1, bz.valido);
    end
    vectors++;
    if (b.dado1 !== 16'h00A5) begin
      miscompares++; $display("FAIL r0_writable: got %h expected 00a5", b.dado1);
    end
    // Same-cycle write and read of register 0: no bypass. Register 1 still bypasses.
    bz.RW = 1'b1; bz.WriteAdd = 3'd0; bz.entrada = 16'hFFFF; bz.Read1Add = 3'd0; bz.Read2Add = 3'd0;
    tick();
    vectors++;
    if (bz.dado1 !== 16'h0000 || bz.dado2 !== 16'h0000) begin
      miscompares++;
      $display("FAIL zero_r0_nobypass: got %h/%h expected 0000/0000", bz.dado1, bz.dado2);
    end
    bz.WriteAdd = 3'd1; bz.entrada = 16'hABCD; bz.Read1Add = 3'd1;
    tick();
    vectors++;
    if (bz.dado1 !== 16'hABCD) begin
      miscompares++; $display("FAIL zero_r0_r1: got %h expected abcd", bz.dado1);
    end
    idle_inputs();
  endtask

  task automatic test_sweep();
    int n;
    for (int i = 0; i < 8; i++) begin
      b.RW = 1'b1; b.WriteAdd = 3'(i); b.entrada = 16'(16'h1000 + i);
      tick();
    end
    // limpa cycle still performs a read.
    b.RW = 1'b0; b.limpa = 1'b1; b.leitura = 1'b1; b.Read1Add = 3'd6; b.Read2Add = 3'd1;
    tick();
    b.limpa = 1'b0;
    vectors++;
    if (b.ocupado !== 1'b1 || b.valido !== 1'b1 || b.dado1 !== 16'h1006 || b.dado2 !== 16'h1001) begin
      miscompares++;
      $display("FAIL sweep_start: got %b/%b/%h/%h expected 1/1/1006/1001",
               b.ocupado, b.valido, b.dado1, b.dado2);
    end
    // Inputs that must be ignored during the sweep.
    b.RW = 1'b1; b.WriteAdd = 3'd7; b.entrada = 16'hFFFF;
    b.leitura = 1'b1; b.Read1Add = 3'd7; b.limpa = 1'b1;
    n = 1;
    while (b.ocupado === 1'b1 && n < 20) begin
      tick();
      n++;
      vectors++;
      if (b.valido !== 1'b0 || b.dado1 !== 16'h1006) begin
        miscompares++;
        $display("FAIL sweep_ignore: got %b/%h expected 0/1006", b.valido, b.dado1);
      end
      if (n == 2) b.limpa = 1'b0;
    end
    idle_inputs();
    // n counts edges from the limpa edge until ocupado falls: DEPTH cycles high.
    vectors++;
    if (n - 1 !== 8) begin
      miscompares++; $display("FAIL sweep_length: got %0d expected 8", n - 1);
    end
    for (int i = 0; i < 8; i++) begin
      b.leitura = 1'b1; b.Read1Add = 3'(i); b.Read2Add = 3'(7 - i);
      tick();
      vectors++;
      if (b.dado1 !== 16'h0000 || b.dado2 !== 16'h0000 || b.valido !== 1'b1) begin
        miscompares++;
        $display("FAIL sweep_clear_%0d: got %h/%h/%b expected 0000/0000/1",
                 i, b.dado1, b.dado2, b.valido);
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_in_sweep();
    for (int i = 0; i < 8; i++) begin
      b.RW = 1'b1; b.WriteAdd = 3'(i); b.entrada = 16'(16'h2000 + i);
      tick();
    end
    b.RW = 1'b0; b.leitura = 1'b1; b.Read1Add = 3'd4;
    tick();
    b.leitura = 1'b0; b.limpa = 1'b1;
    tick();
    b.limpa = 1'b0;
    // Four sweep edges bring the index to 4.
    for (int i = 0; i < 4; i++) tick();
    vectors++;
    if (b.ocupado !== 1'b1 || b.dado1 !== 16'h2004) begin
      miscompares++;
      $display("FAIL pre_abort: got %b/%h expected 1/2004", b.ocupado, b.dado1);
    end
    reset_n = 1'b0;
    #2;
    vectors++;
    if (b.ocupado !== 1'b0 || b.dado1 !== 16'h0000 || b.valido !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_reset: got %b/%h/%b expected 0/0000/0", b.ocupado, b.dado1, b.valido);
    end
    @(negedge clock);
    reset_n = 1'b1;
    b.RW = 1'b1; b.WriteAdd = 3'd5; b.entrada = 16'h5A5A;
    tick();
    b.RW = 1'b0; b.leitura = 1'b1; b.Read1Add = 3'd5; b.Read2Add = 3'd6;
    tick();
    vectors++;
    if (b.dado1 !== 16'h5A5A || b.dado2 !== 16'h0000 || b.ocupado !== 1'b0) begin
      miscompares++;
      $display("FAIL post_abort_write: got %h/%h/%b expected 5a5a/0000/0",
               b.dado1, b.dado2, b.ocupado);
    end
    b.Read1Add = 3'd4; b.Read2Add = 3'd7;
    tick();
    vectors++;
    if (b.dado1 !== 16'h0000 || b.dado2 !== 16'h0000) begin
      miscompares++;
      $display("FAIL post_abort_clear: got %h/%h expected 0000/0000", b.dado1, b.dado2);
    end
    idle_inputs();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset_n     = 1'b0;
    test_reset();
    test_write_read();
    test_bypass();
    test_zero_r0();
    test_sweep();
    test_reset_in_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
